// File: rtl/game_pkg.sv
// Shared constants and types for the playfield game blocks.
package game_pkg;

    localparam int FIELD_W   = 1024;
    localparam int FIELD_H   = 768;
    localparam int MARGIN_LO = 5;
    localparam int MARGIN_HI = 10;

    localparam int N_SLOTS = 15;
    localparam int COORD_W = 11;

    localparam int X_MIN = MARGIN_LO;
    localparam int X_MAX = FIELD_W - MARGIN_HI;
    localparam int Y_MIN = MARGIN_LO;
    localparam int Y_MAX = FIELD_H - MARGIN_HI;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        DRAW_X,
        DRAW_Y,
        WRITE
    } spawn_state_t;

    typedef logic [3:0] slot_idx_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, free-running whenever reset is low.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED,
    parameter logic [15:0] MASK = LFSR_MASK
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/point_spawn_ctrl.sv
// Point table owner: periodic spawn of random in-range points
// into the lowest free slot, with a retire port for game logic.
module point_spawn_ctrl #(
    parameter int          TICK_CYCLES = 65000000,
    parameter int          N_SLOTS     = game_pkg::N_SLOTS,
    parameter int          COORD_W     = game_pkg::COORD_W,
    parameter int          X_MIN       = game_pkg::X_MIN,
    parameter int          X_MAX       = game_pkg::X_MAX,
    parameter int          Y_MIN       = game_pkg::Y_MIN,
    parameter int          Y_MAX       = game_pkg::Y_MAX,
    parameter logic [15:0] LFSR_SEED   = game_pkg::LFSR_SEED
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             collect_valid,
    input  logic [3:0]                       collect_idx,
    output logic [N_SLOTS-1:0][COORD_W-1:0]  position_x,
    output logic [N_SLOTS-1:0][COORD_W-1:0]  position_y,
    output logic [N_SLOTS-1:0]               point_valid,
    output logic                             spawn_pulse,
    output logic [3:0]                       spawn_idx,
    output logic                             table_full
);

    import game_pkg::*;

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [COORD_W-1:0] XLO      = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] XHI      = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YLO      = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] YHI      = COORD_W'(Y_MAX);
    localparam slot_idx_t          LAST_IDX = slot_idx_t'(N_SLOTS - 1);

    spawn_state_t       state;
    spawn_state_t       state_nxt;
    logic [CNT_W-1:0]   tick_cnt;
    logic               tick;
    logic               pending;
    logic [15:0]        lfsr;
    logic               unused_lfsr;
    logic [COORD_W-1:0] cand;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    logic               x_ok;
    logic               y_ok;
    logic               take;
    logic               latch_x;
    logic               latch_y;
    logic               write_en;
    slot_idx_t          target;
    logic [N_SLOTS-1:0] valid_nxt;

    function automatic slot_idx_t first_free(input logic [N_SLOTS-1:0] v);
        first_free = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!v[i]) first_free = slot_idx_t'(i);
        end
    endfunction

    lfsr16 #(
        .SEED (LFSR_SEED),
        .MASK (LFSR_MASK)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:10];
    assign cand        = COORD_W'(lfsr[9:0]);
    assign x_ok        = (cand >= XLO) && (cand <= XHI);
    assign y_ok        = (cand >= YLO) && (cand <= YHI);
    assign table_full  = &point_valid;
    assign target      = first_free(point_valid);
    assign tick        = enable && (tick_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        latch_x   = 1'b0;
        latch_y   = 1'b0;
        write_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) begin
                    take = 1'b1;
                    if (!table_full) state_nxt = DRAW_X;
                end
            end
            DRAW_X: begin
                if (x_ok) begin
                    latch_x   = 1'b1;
                    state_nxt = DRAW_Y;
                end
            end
            DRAW_Y: begin
                if (y_ok) begin
                    latch_y   = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                write_en  = !table_full;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A tick landing while a spawn is already pending is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            pending  <= 1'b0;
            cx       <= '0;
            cy       <= '0;
        end else begin
            if (tick) begin
                tick_cnt <= '0;
            end else if (enable) begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
            if (take) begin
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end
            if (latch_x) cx <= cand;
            if (latch_y) cy <= cand;
        end
    end

    // Write uses the pre-collect free set, so it wins on a shared slot.
    always_comb begin
        valid_nxt = point_valid;
        if (collect_valid && (collect_idx <= LAST_IDX)) begin
            valid_nxt[collect_idx] = 1'b0;
        end
        if (write_en) begin
            valid_nxt[target] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            position_x  <= '0;
            position_y  <= '0;
            point_valid <= '0;
            spawn_pulse <= 1'b0;
            spawn_idx   <= '0;
        end else begin
            point_valid <= valid_nxt;
            spawn_pulse <= write_en;
            if (write_en) begin
                position_x[target] <= cx;
                position_y[target] <= cy;
                spawn_idx          <= target;
            end
        end
    end

endmodule
